// File: rtl/pc_fetch_stage.sv
// Fetch stage: next-PC selection, instruction-memory addressing and the IF/ID
// pipeline register, with a boot cycle and a halt on a misaligned jump target.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  branch_sel,
  input  logic [31:0] id_pc,
  input  logic [31:0] imm,
  input  logic [31:0] busA,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        redirect,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_seq, target;
  logic [31:0] if_id_pc_next, if_id_inst_next, trap_pc_next;
  logic        if_id_valid_next, trap_next;
  logic        take;

  assign pc_seq    = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == RUN);
  assign take      = (branch_sel == 2'b01) || (branch_sel == 2'b10);

  always_comb begin
    target = pc_seq;
    unique case (branch_sel)
      2'b01:   target = id_pc + imm;
      2'b10:   target = (busA + imm) & ~32'd1;
      default: target = pc_seq;
    endcase
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_inst_next  = if_id_inst;
    if_id_valid_next = if_id_valid;
    trap_next        = misalign_trap;
    trap_pc_next     = trap_pc;
    redirect         = 1'b0;
    unique case (state)
      BOOT: begin
        state_next       = RUN;
        if_id_pc_next    = '0;
        if_id_inst_next  = NOP_INST;
        if_id_valid_next = 1'b0;
      end
      RUN: begin
        if (!stall) begin
          if (take) begin
            // Both trap and redirect squash the wrong-path fetch at the old pc.
            if_id_pc_next    = '0;
            if_id_inst_next  = NOP_INST;
            if_id_valid_next = 1'b0;
            if (target[1]) begin
              trap_next    = 1'b1;
              trap_pc_next = target;
              state_next   = HALT;
            end else begin
              pc_next  = target;
              redirect = 1'b1;
            end
          end else begin
            pc_next          = pc_seq;
            if_id_pc_next    = pc;
            if_id_inst_next  = imem_rdata;
            if_id_valid_next = 1'b1;
          end
        end
      end
      default: begin
        if_id_pc_next    = '0;
        if_id_inst_next  = NOP_INST;
        if_id_valid_next = 1'b0;
        trap_next        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      if_id_pc      <= '0;
      if_id_inst    <= NOP_INST;
      if_id_valid   <= 1'b0;
      misalign_trap <= 1'b0;
      trap_pc       <= '0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      if_id_pc      <= if_id_pc_next;
      if_id_inst    <= if_id_inst_next;
      if_id_valid   <= if_id_valid_next;
      misalign_trap <= trap_next;
      trap_pc       <= trap_pc_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: each row drives one cycle of inputs and
// queues the hand-computed outputs expected during that cycle.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  branch_sel = 2'b00;
  logic [31:0] id_pc = '0, imm = '0, busA = '0;
  logic [31:0] imem_rdata, imem_addr, if_id_pc, if_id_inst, trap_pc;
  logic        imem_req, if_id_valid, redirect, misalign_trap;

  typedef struct packed {
    logic [31:0] addr;
    logic        req;
    logic        red;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        valid;
    logic        trap;
    logic [31:0] tpc;
  } obs_t;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   row_no = 0;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_sel(branch_sel),
    .id_pc(id_pc), .imm(imm), .busA(busA), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .imem_req(imem_req), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .redirect(redirect),
    .misalign_trap(misalign_trap), .trap_pc(trap_pc)
  );

  // Instruction memory: word at address a reads as 0xA0 + a.
  assign imem_rdata = 32'h0000_00A0 + imem_addr;

  always #5 clk = ~clk;

  task automatic row(input logic r, input logic s, input logic [1:0] sel,
                     input logic [31:0] ip, input logic [31:0] im, input logic [31:0] ba,
                     input logic [31:0] e_addr, input logic e_req, input logic e_red,
                     input logic [31:0] e_ipc, input logic [31:0] e_inst, input logic e_v,
                     input logic e_trap, input logic [31:0] e_tpc);
    obs_t e;
    @(negedge clk);
    rst_n = r; stall = s; branch_sel = sel; id_pc = ip; imm = im; busA = ba;
    e.addr = e_addr; e.req = e_req; e.red = e_red; e.ipc = e_ipc;
    e.inst = e_inst; e.valid = e_v; e.trap = e_trap; e.tpc = e_tpc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{imem_addr, imem_req, redirect, if_id_pc, if_id_inst, if_id_valid,
              misalign_trap, trap_pc};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL row%0d: got addr=%h req=%b red=%b ifid=%h/%h/%b trap=%b/%h, want addr=%h req=%b red=%b ifid=%h/%h/%b trap=%b/%h",
                   row_no, a.addr, a.req, a.red, a.ipc, a.inst, a.valid, a.trap, a.tpc,
                   e.addr, e.req, e.red, e.ipc, e.inst, e.valid, e.trap, e.tpc);
        end
        row_no++;
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    // reset, boot, sequential fetch
    row(0,0,2'b00, 0,0,0,  32'h0,1'b0,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h0,1'b0,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h0,1'b1,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h4,1'b1,1'b0, 32'h0,32'hA0,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h8,1'b1,1'b0, 32'h4,32'hA4,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'hC,1'b1,1'b0, 32'h8,32'hA8,1'b1, 1'b0,32'h0);
    // stall with a pending branch select
    for (int i = 0; i < 3; i++)
      row(1,1,2'b01, 32'h20,32'h40,0,  32'h10,1'b1,1'b0, 32'hC,32'hAC,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h10,1'b1,1'b0, 32'hC,32'hAC,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h14,1'b1,1'b0, 32'h10,32'hB0,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h18,1'b1,1'b0, 32'h14,32'hB4,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h1C,1'b1,1'b0, 32'h18,32'hB8,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h20,1'b1,1'b0, 32'h1C,32'hBC,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h24,1'b1,1'b0, 32'h20,32'hC0,1'b1, 1'b0,32'h0);
    // branch id_pc+imm = 0x60 from pc 0x28
    row(1,0,2'b01, 32'h20,32'h40,0,  32'h28,1'b1,1'b1, 32'h24,32'hC4,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h60,1'b1,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    // aligned jalr 0x201+3 -> 0x204, then back-to-back branch to 0xFFFFFFFC
    row(1,0,2'b10, 0,32'h3,32'h201,  32'h64,1'b1,1'b1, 32'h60,32'h100,1'b1, 1'b0,32'h0);
    row(1,0,2'b01, 32'h1000,32'hFFFF_EFFC,0,  32'h204,1'b1,1'b1, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'hFFFF_FFFC,1'b1,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    // wrap, then reserved select acts as pc+4
    row(1,0,2'b11, 32'h20,32'h40,32'h100,  32'h0,1'b1,1'b0, 32'hFFFF_FFFC,32'h9C,1'b1, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h4,1'b1,1'b0, 32'h0,32'hA0,1'b1, 1'b0,32'h0);
    // misaligned jalr 0x103 -> 0x102 traps and halts
    row(1,0,2'b10, 0,32'h0,32'h103,  32'h8,1'b1,1'b0, 32'h4,32'hA4,1'b1, 1'b0,32'h0);
    for (int i = 0; i < 6; i++)
      row(1,0,(i % 2 == 0) ? 2'b00 : 2'b01, 32'h20,32'h40,0,
          32'h8,1'b0,1'b0, 32'h0,NOP,1'b0, 1'b1,32'h102);
    // asynchronous reset clears the sticky trap, then boot again
    row(0,0,2'b00, 0,0,0,  32'h0,1'b0,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h0,1'b0,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h0,1'b1,1'b0, 32'h0,NOP,1'b0, 1'b0,32'h0);
    row(1,0,2'b00, 0,0,0,  32'h4,1'b1,1'b0, 32'h0,32'hA0,1'b1, 1'b0,32'h0);

    @(negedge clk);
    #6;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Fetch-stage block directly downstream of the branch control unit. It consumes the 2-bit PC-select code and turns it into the next program counter. It drives the instruction-memory address and owns the IF/ID pipeline register, including bubble insertion on redirects and stall hold. A small FSM covers boot and halt-on-misaligned-target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, encoding placed in IF/ID on bubble (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard hold; freezes PC and IF/ID
branch_sel  input  2  PC select from branch control: 00 pc+4, 01 id_pc+imm, 10 busA+imm (jalr), 11 reserved
id_pc  input  32  PC of the instruction currently in ID
imm  input  32  sign-extended immediate of the ID instruction
busA  input  32  rs1 value, used for jalr
imem_rdata  input  32  instruction word at imem_addr, combinational same cycle
imem_addr  output  32  current PC
imem_req  output  1  fetch enable
if_id_pc  output  32  registered PC of the fetched instruction
if_id_inst  output  32  registered instruction
if_id_valid  output  1  IF/ID holds a real instruction
redirect  output  1  combinational; a redirect is accepted this cycle
misalign_trap  output  1  sticky; set on misaligned target
trap_pc  output  32  offending target address

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0
  - misalign_trap=0, trap_pc=0, state=BOOT
- imem_addr=pc at all times. imem_req=1 only in RUN.
- FSM states:
  - BOOT: exactly one cycle after reset release. imem_req=0, pc held, IF/ID loads bubble. Goes to RUN unconditionally; stall is ignored.
  - RUN: normal fetch; see the per-cycle rules below.
  - HALT: imem_req=0, pc frozen, IF/ID held at bubble (valid=0), misalign_trap=1. Exit only via reset.
- Target computation, 32-bit wrap-around with no overflow detection:
  - 00: pc+4
  - 01: id_pc+imm
  - 10: (busA+imm) with bit0 forced to 0
  - 11: treated as 00
- Per RUN cycle, in priority order:
  1. stall=1: pc and all IF/ID registers hold. branch_sel is ignored. redirect=0.
  2. branch_sel in {01,10} and target[1]=1 (misaligned): trap_pc<=target, misalign_trap<=1, pc holds, IF/ID loads bubble, next state HALT. redirect=0.
  3. branch_sel in {01,10}, aligned: pc<=target and redirect=1. IF/ID loads bubble (inst=NOP_INST, pc=0, valid=0), squashing the wrong-path fetch at the old pc.
  4. Otherwise: pc<=pc+4. IF/ID loads if_id_pc<=pc, if_id_inst<=imem_rdata, if_id_valid<=1.
- Redirect penalty is one bubble cycle. The instruction at the target reaches IF/ID on the second edge after the redirect.
- Back-to-back redirects: each one is accepted independently. No two consecutive cycles can both carry a valid IF/ID instruction across a redirect.
- pc at 32'hFFFF_FFFC with sequential fetch wraps to 32'h0000_0000 with no flag.
- Reset asserted mid-operation (any state) returns immediately to reset values, including clearing a sticky trap.
- pc[1:0] is always 00 after reset, given an aligned RESET_PC.

Test Plan:
1. Reset release with RESET_PC=0, branch_sel=00, imem returning 0xA0+addr → BOOT cycle has imem_req=0, valid=0; then if_id_pc steps 0,4,8 with matching inst and valid=1.
2. In RUN at pc=0x10, stall=1 for 3 cycles with branch_sel=01 → pc stays 0x10, IF/ID unchanged, redirect=0; after stall drops, fetch resumes at 0x10.
3. Branch_sel=01, id_pc=0x20, imm=0x40, pc=0x28 → redirect=1, next pc=0x60, one bubble (inst=0x00000013, valid=0), then if_id_pc=0x60 valid=1.
4. jalr: branch_sel=10, busA=0x103, imm=0x0 → target 0x102, misaligned → trap_pc=0x102, misalign_trap=1, HALT, imem_req=0, valid=0 held for 5+ cycles; then rst_n=0 clears all.
5. jalr aligned: busA=0x201, imm=0x3 → target 0x204 (bit0 cleared, bit1=0), redirect accepted, no trap.
6. pc=0xFFFF_FFFC sequential → next pc 0x0000_0000; branch_sel=11 → behaves as pc+4, no redirect.
